// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit CPU; min 4 cycles per instruction (LW 5).
// Memory backpressure via mem_req/mem_ready: stalls in FETCH/MEM, and MEM_WAIT_MAX idle cycles -> sticky ERROR.
module multicycle_sequencer #(
  parameter int CNT_W        = 8,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_en,
  output logic             reg_write,
  output logic             alu_src,
  output logic             reg_write_src,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [1:0] opRType = 2'b00;
  localparam logic [1:0] opLw    = 2'b01;
  localparam logic [1:0] opSw    = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd7
  } stateT;

  stateT             stateQ;
  logic [1:0]        opQ;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  instrCnt;
  logic              waitLimit;

  // The cycle that would push waitCnt up to MEM_WAIT_MAX is the last one allowed.
  assign waitLimit = (waitCnt == WAIT_W'(MEM_WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= IDLE;
      opQ      <= '0;
      waitCnt  <= '0;
      instrCnt <= '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (run) begin
            stateQ  <= FETCH;
            waitCnt <= '0;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            stateQ  <= DECODE;
            waitCnt <= '0;
          end else if (waitLimit) begin
            stateQ <= ERROR;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DECODE: begin
          opQ    <= opcode;
          stateQ <= EXEC;
        end
        EXEC: begin
          if (opQ == opLw || opQ == opSw) begin
            stateQ  <= MEM;
            waitCnt <= '0;
          end else begin
            stateQ <= WB;
          end
        end
        MEM: begin
          if (mem_ready) begin
            waitCnt <= '0;
            if (opQ == opSw) begin
              instrCnt <= instrCnt + 1'b1;
              stateQ   <= run ? FETCH : IDLE;
            end else begin
              stateQ <= WB;
            end
          end else if (waitLimit) begin
            stateQ <= ERROR;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        WB: begin
          instrCnt <= instrCnt + 1'b1;
          waitCnt  <= '0;
          stateQ   <= run ? FETCH : IDLE;
        end
        ERROR:   stateQ <= ERROR;
        default: stateQ <= IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state; only the fetch-accept pulse looks at mem_ready.
  assign state         = stateQ;
  assign mem_req       = (stateQ == FETCH) || (stateQ == MEM);
  assign mem_we        = (stateQ == MEM) && (opQ == opSw);
  assign ir_load       = (stateQ == FETCH) && mem_ready;
  assign pc_en         = (stateQ == FETCH) && mem_ready;
  assign reg_write     = (stateQ == WB);
  assign alu_src       = (stateQ == MEM) ||
                         (((stateQ == EXEC) || (stateQ == WB)) && (opQ != opRType));
  assign reg_write_src = (stateQ == WB) && (opQ == opLw);
  assign busy          = (stateQ == FETCH) || (stateQ == DECODE) || (stateQ == EXEC) ||
                         (stateQ == MEM) || (stateQ == WB);
  assign err           = (stateQ == ERROR);
  assign instr_count   = instrCnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle expected state/strobes/count queued and checked.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [1:0] opcode;
  logic       memReady;
  logic       memReq, memWe, irLoad, pcEn, regWrite, aluSrc, regWriteSrc, busy, err;
  logic [2:0] state;
  logic [7:0] instrCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } sbT;
  sbT sb[$];

  multicycle_sequencer #(.CNT_W(8), .MEM_WAIT_MAX(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .mem_ready    (memReady),
    .mem_req      (memReq),
    .mem_we       (memWe),
    .ir_load      (irLoad),
    .pc_en        (pcEn),
    .reg_write    (regWrite),
    .alu_src      (aluSrc),
    .reg_write_src(regWriteSrc),
    .busy         (busy),
    .err          (err),
    .state        (state),
    .instr_count  (instrCount)
  );

  always #5 clk = ~clk;

  // Expected {mem_req, mem_we, ir_load, pc_en, reg_write, alu_src, reg_write_src, busy, err}
  function automatic logic [8:0] expOut(input logic [2:0] st, input logic [1:0] op, input logic rdy);
    logic f, e, m, w;
    f = (st == 3'd1);
    e = (st == 3'd3);
    m = (st == 3'd4);
    w = (st == 3'd5);
    return {f | m, m & (op == 2'b10), f & rdy, f & rdy, w,
            m | ((e | w) & (op != 2'b00)), w & (op == 2'b01),
            (st >= 3'd1) && (st <= 3'd5), st == 3'd7};
  endfunction

  // Drive one cycle of inputs, queue the expectation for this cycle, check it mid-cycle.
  task automatic cyc(input string tag, input logic rst, input logic r, input logic [1:0] op,
                     input logic rdy, input logic [2:0] st, input logic [7:0] cnt);
    sbT          e;
    logic [19:0] obs;
    reset    = rst;
    run      = r;
    opcode   = op;
    memReady = rdy;
    e.tag = tag;
    e.exp = {st, expOut(st, op, rdy), cnt};
    sb.push_back(e);
    @(negedge clk);
    e   = sb.pop_front();
    obs = {state, memReq, memWe, irLoad, pcEn, regWrite, aluSrc, regWriteSrc, busy, err, instrCount};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    opcode   = 2'b00;
    memReady = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1, 0, 2'b00, 0, 3'd0, 8'd0);

    // R-type back to back with memory always ready
    cyc("t1_idle", 0, 1, 2'b00, 1, 3'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("t1_fetch",  0, 1, 2'b00, 1, 3'd1, 8'(i));
      cyc("t1_decode", 0, 1, 2'b00, 1, 3'd2, 8'(i));
      cyc("t1_exec",   0, 1, 2'b00, 1, 3'd3, 8'(i));
      cyc("t1_wb",     0, 1, 2'b00, 1, 3'd5, 8'(i));
    end

    // LW
    cyc("t2_fetch",  0, 1, 2'b01, 1, 3'd1, 8'd3);
    cyc("t2_decode", 0, 1, 2'b01, 1, 3'd2, 8'd3);
    cyc("t2_exec",   0, 1, 2'b01, 1, 3'd3, 8'd3);
    cyc("t2_mem",    0, 1, 2'b01, 1, 3'd4, 8'd3);
    cyc("t2_wb",     0, 1, 2'b01, 1, 3'd5, 8'd3);

    // SW retires on the MEM exit edge
    cyc("t3_fetch",  0, 1, 2'b10, 1, 3'd1, 8'd4);
    cyc("t3_decode", 0, 1, 2'b10, 1, 3'd2, 8'd4);
    cyc("t3_exec",   0, 1, 2'b10, 1, 3'd3, 8'd4);
    cyc("t3_mem",    0, 1, 2'b10, 1, 3'd4, 8'd4);

    // Fetch stalled three cycles
    for (int i = 0; i < 3; i++) cyc("t4_fetch_wait", 0, 1, 2'b00, 0, 3'd1, 8'd5);
    cyc("t4_fetch_go", 0, 1, 2'b00, 1, 3'd1, 8'd5);
    cyc("t4_decode",   0, 1, 2'b00, 1, 3'd2, 8'd5);
    cyc("t4_exec",     0, 1, 2'b00, 1, 3'd3, 8'd5);
    cyc("t4_wb",       0, 1, 2'b00, 1, 3'd5, 8'd5);

    // run dropped during ADDI EXEC: instruction finishes, then IDLE
    cyc("t6_fetch",    0, 1, 2'b11, 1, 3'd1, 8'd6);
    cyc("t6_decode",   0, 1, 2'b11, 1, 3'd2, 8'd6);
    cyc("t6_exec",     0, 0, 2'b11, 1, 3'd3, 8'd6);
    cyc("t6_wb",       0, 0, 2'b11, 1, 3'd5, 8'd6);
    cyc("t6_idle",     0, 0, 2'b11, 1, 3'd0, 8'd7);
    cyc("t6_idle_run", 0, 1, 2'b01, 1, 3'd0, 8'd7);

    // LW whose data phase never completes -> ERROR
    cyc("t5_fetch",  0, 1, 2'b01, 1, 3'd1, 8'd7);
    cyc("t5_decode", 0, 1, 2'b01, 1, 3'd2, 8'd7);
    cyc("t5_exec",   0, 1, 2'b01, 1, 3'd3, 8'd7);
    for (int i = 0; i < 15; i++) cyc("t5_mem_wait", 0, 1, 2'b01, 0, 3'd4, 8'd7);
    for (int i = 0; i < 3; i++) cyc("t5_error", 0, 1, 2'b01, 1, 3'd7, 8'd7);
    cyc("t5_error_rst",   1, 0, 2'b00, 0, 3'd7, 8'd7);
    cyc("t5_after_reset", 0, 0, 2'b00, 0, 3'd0, 8'd0);

    // Fetch completes exactly at the timeout limit, then reset aborts an LW in MEM
    cyc("t7_idle", 0, 1, 2'b00, 0, 3'd0, 8'd0);
    for (int i = 0; i < 14; i++) cyc("t7_fetch_wait", 0, 1, 2'b00, 0, 3'd1, 8'd0);
    cyc("t7_fetch_limit", 0, 1, 2'b00, 1, 3'd1, 8'd0);
    cyc("t7_decode",      0, 1, 2'b00, 1, 3'd2, 8'd0);
    cyc("t7_exec",        0, 1, 2'b00, 1, 3'd3, 8'd0);
    cyc("t7_wb",          0, 1, 2'b00, 1, 3'd5, 8'd0);
    cyc("t7_lw_fetch",    0, 1, 2'b01, 1, 3'd1, 8'd1);
    cyc("t7_lw_decode",   0, 1, 2'b01, 1, 3'd2, 8'd1);
    cyc("t7_lw_exec",     0, 1, 2'b01, 1, 3'd3, 8'd1);
    cyc("t7_lw_mem",      0, 1, 2'b01, 0, 3'd4, 8'd1);
    cyc("t7_mem_reset",   1, 1, 2'b01, 0, 3'd4, 8'd1);
    cyc("t7_after_reset", 0, 0, 2'b01, 0, 3'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
